rf_wb_arb: RTL and testbench
============================

# rf_wb_arb

Writeback arbiter sitting directly upstream of the CPU register file's two write ports. It forwards execute-pipe results, buffers out-of-order load returns in a small FIFO, and merges both onto write port 1. It also keeps a per-physical-register load scoreboard, so decode can stall on reads and writes of registers whose load has not yet retired.

## Interface
- FIFO_DEPTH, 2: load-return buffer entries; power of two, ≥2.
- STARVE_MAX, 4: consecutive cycles the FIFO head may be blocked by ex1 before `ex1_stall` is raised.

Ports:
- clk  in  1  sole clock; all state on posedge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- ex0_wen / ex0_wdst / ex0_wbank / ex0_wdata  in  1/4/1/32  pipe-0 result.
- ex1_wen / ex1_wdst / ex1_wbank / ex1_wdata  in  1/4/1/32  pipe-1 result.
- ex1_stall  out  1  upstream must hold `ex1_wen` low in any cycle this is high.
- ld_issue / ld_issue_dst / ld_issue_bank  in  1/4/1  load issued to the given destination.
- ld_issue_ready  out  1  target register not already pending.
- ld_rvalid / ld_rdst / ld_rbank / ld_rdata  in  1/4/1/32  load return.
- ld_rready  out  1  FIFO not full.
- rf_wen0 / rf_wdst0 / rf_wbank0 / rf_wdata0  out  1/4/1/32  to RF write port 0.
- rf_wen1 / rf_wdst1 / rf_wbank1 / rf_wdata1  out  1/4/1/32  to RF write port 1.
- chk_src0..3 / chk_bank0..3  in  4/1 each  decode-side register queries.
- chk_hit0..3  out  1 each  queried register has a pending load.
- ld_outstanding  out  5  count of set scoreboard bits.

## Operation
- Physical index, 24 entries:
  - `!dst[3] && bank` → 16+dst[2:0] (banked R0–R7).
  - otherwise → dst (R0–R15 bank0; R8–R15 shared).
- Port 0 is a combinational pass-through of ex0.
- Port 1 selection:
  - if `ex1_wen`: drive ex1;
  - else if FIFO non-empty: drive FIFO head and pop (a drain);
  - else `rf_wen1`=0.
- Load return accepted on `ld_rvalid && ld_rready` and pushed into the FIFO.
  - Never bypassed; earliest write is the cycle after acceptance.
- Scoreboard:
  - bit set on `ld_issue`;
  - bit cleared at the posedge where a drain of that index occurs.
  - Set and clear of different indices in one cycle both apply.
  - `ld_outstanding` equals popcount of the scoreboard at all times; it is an incrementally maintained counter and is checked against popcount by assertion.
- `ld_issue_ready` = !scoreboard[idx(ld_issue_dst, ld_issue_bank)]. Issuing while not ready is illegal (assertion).
- `chk_hitN` = scoreboard[idx(chk_srcN, chk_bankN)], combinational.
  - Decode checks both sources and destination.
  - ex0/ex1 writes to a pending index are illegal (assertion).
- Starvation counter:
  - increments each cycle the FIFO is non-empty and `ex1_wen`=1;
  - resets to 0 on any drain or when the FIFO is empty;
  - `ex1_stall` = (count ≥ STARVE_MAX); it drops after the drain occurs.
- Full FIFO: `ld_rready`=0; return is held upstream.
  - Push and pop in the same cycle while full is not possible, because `ld_rready` is evaluated before the pop.
- Load return for an index whose scoreboard bit is clear is illegal (assertion).

## Timing
- Reset (async, rst_n low):
  - FIFO empty, scoreboard 0, starvation count 0;
  - `ld_rready`=1, `ld_issue_ready`=1, `chk_hit*`=0, `ld_outstanding`=0, `ex1_stall`=0;
  - port outputs follow ex inputs combinationally (port 1 shows ex1 only).
- Reset asserted mid-operation discards buffered loads and pending bits; no write is emitted for them.
- Port 0 / ex1 path latency: 0 cycles (RF writes at the same edge).
- Load latency:
  - accept at edge N; earliest RF write and scoreboard clear at edge N+1;
  - `chk_hit` low and RF data readable in cycle N+1.
- `ld_issue` in cycle N: `chk_hit`/`ld_issue_ready` reflect the pending bit from cycle N+1.

## Test plan
- Reset, then ex0 R3=0x11, ex1 R4=0x22 in the same cycle → `rf_wen0`/`rf_wen1` both 1 in that cycle; R3/R4 hold values next cycle.
- Issue load R5 bank1 (idx 21) → `chk_hit` for R5/bank1 is 1 and for R5/bank0 is 0; `ld_outstanding`=1. Return 0xDEAD at edge N with ex1 idle → write at N+1; `ld_outstanding`=0.
- Issue R9 and R1; return R1 then R9 while ex1 busy → FIFO fills (`ld_rready`=0 with depth 2); in-order drains when ex1 goes idle.
- Keep ex1_wen=1 continuously with 1 load buffered → `ex1_stall` rises after 4 blocked cycles; with ex1 held low, the drain occurs next cycle and `ex1_stall` falls.
- Issue R8 bank1 → `ld_issue_ready` for R8 bank0 is 0 (shared index 8).
- Assert rst_n low with 2 entries buffered and 3 pending → all counters 0 asynchronously; no `rf_wen1` pulses after release.

Source files
------------

// File: rtl/rf_wb_arb.sv
// rtl/rf_wb_arb.sv - writeback arbiter: ex pass-through, load-return FIFO, load scoreboard
module rf_wb_arb #(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex0_wen,
    input  logic [3:0]  ex0_wdst,
    input  logic        ex0_wbank,
    input  logic [31:0] ex0_wdata,
    input  logic        ex1_wen,
    input  logic [3:0]  ex1_wdst,
    input  logic        ex1_wbank,
    input  logic [31:0] ex1_wdata,
    output logic        ex1_stall,
    input  logic        ld_issue,
    input  logic [3:0]  ld_issue_dst,
    input  logic        ld_issue_bank,
    output logic        ld_issue_ready,
    input  logic        ld_rvalid,
    input  logic [3:0]  ld_rdst,
    input  logic        ld_rbank,
    input  logic [31:0] ld_rdata,
    output logic        ld_rready,
    output logic        rf_wen0,
    output logic [3:0]  rf_wdst0,
    output logic        rf_wbank0,
    output logic [31:0] rf_wdata0,
    output logic        rf_wen1,
    output logic [3:0]  rf_wdst1,
    output logic        rf_wbank1,
    output logic [31:0] rf_wdata1,
    input  logic [3:0]  chk_src0,
    input  logic [3:0]  chk_src1,
    input  logic [3:0]  chk_src2,
    input  logic [3:0]  chk_src3,
    input  logic        chk_bank0,
    input  logic        chk_bank1,
    input  logic        chk_bank2,
    input  logic        chk_bank3,
    output logic        chk_hit0,
    output logic        chk_hit1,
    output logic        chk_hit2,
    output logic        chk_hit3,
    output logic [4:0]  ld_outstanding
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [3:0]  dst;
        logic        bank;
        logic [31:0] data;
    } ent_t;

    // Banked R0-R7 live at 16..23; R8-R15 are shared between banks.
    function automatic logic [4:0] phys_idx(input logic [3:0] dst, input logic bank);
        return (!dst[3] && bank) ? {2'b10, dst[2:0]} : {1'b0, dst};
    endfunction

    ent_t          mem_q [FIFO_DEPTH];
    ent_t          mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [23:0]   sb_q, sb_d;
    logic [4:0]    out_q, out_d;
    logic [CW-1:0] starve_q, starve_d;

    logic          empty, full, push, pop;
    ent_t          head;
    logic [4:0]    head_idx, issue_idx;

    always_comb begin
        empty     = (cnt_q == '0);
        full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
        head      = mem_q[rd_ptr_q];
        head_idx  = phys_idx(head.dst, head.bank);
        issue_idx = phys_idx(ld_issue_dst, ld_issue_bank);
        push      = ld_rvalid && !full;
        pop       = !ex1_wen && !empty;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{dst: ld_rdst, bank: ld_rbank, data: ld_rdata};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end

        // Clear applies before set so the counter stays equal to the popcount.
        sb_d  = sb_q;
        out_d = out_q;
        if (pop && sb_q[head_idx]) begin
            sb_d[head_idx] = 1'b0;
            out_d          = out_d - 5'd1;
        end
        if (ld_issue && !sb_d[issue_idx]) begin
            sb_d[issue_idx] = 1'b1;
            out_d           = out_d + 5'd1;
        end

        starve_d = starve_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if (ex1_wen && (starve_q != CW'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            sb_q     <= '0;
            out_q    <= '0;
            starve_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            sb_q     <= sb_d;
            out_q    <= out_d;
            starve_q <= starve_d;
        end
    end

    assign rf_wen0   = ex0_wen;
    assign rf_wdst0  = ex0_wdst;
    assign rf_wbank0 = ex0_wbank;
    assign rf_wdata0 = ex0_wdata;

    assign rf_wen1   = ex1_wen || !empty;
    assign rf_wdst1  = ex1_wen ? ex1_wdst  : head.dst;
    assign rf_wbank1 = ex1_wen ? ex1_wbank : head.bank;
    assign rf_wdata1 = ex1_wen ? ex1_wdata : head.data;

    assign ld_rready      = !full;
    assign ld_issue_ready = !sb_q[issue_idx];
    assign ld_outstanding = out_q;
    assign ex1_stall      = (starve_q >= CW'(STARVE_MAX));

    assign chk_hit0 = sb_q[phys_idx(chk_src0, chk_bank0)];
    assign chk_hit1 = sb_q[phys_idx(chk_src1, chk_bank1)];
    assign chk_hit2 = sb_q[phys_idx(chk_src2, chk_bank2)];
    assign chk_hit3 = sb_q[phys_idx(chk_src3, chk_bank3)];

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (ld_outstanding == 5'($countones(sb_q)))
                else $error("rf_wb_arb: outstanding counter disagrees with scoreboard");
            assert (!ld_issue || ld_issue_ready)
                else $error("rf_wb_arb: load issued to a pending register");
            assert (!ex0_wen || !sb_q[phys_idx(ex0_wdst, ex0_wbank)])
                else $error("rf_wb_arb: ex0 write to a pending register");
            assert (!ex1_wen || !sb_q[phys_idx(ex1_wdst, ex1_wbank)])
                else $error("rf_wb_arb: ex1 write to a pending register");
            assert (!push || sb_q[phys_idx(ld_rdst, ld_rbank)])
                else $error("rf_wb_arb: load return without pending bit");
            assert (!ex1_stall || !ex1_wen)
                else $error("rf_wb_arb: ex1 write while stalled");
        end
    end
`endif
endmodule

// File: tb/tb_rf_wb_arb.sv
// tb/tb_rf_wb_arb.sv - directed self-checking bench for rf_wb_arb
module tb_rf_wb_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex0_wen, ex1_wen, ex0_wbank, ex1_wbank;
    logic [3:0]  ex0_wdst, ex1_wdst;
    logic [31:0] ex0_wdata, ex1_wdata;
    logic        ex1_stall;
    logic        ld_issue, ld_issue_bank, ld_issue_ready;
    logic [3:0]  ld_issue_dst;
    logic        ld_rvalid, ld_rbank, ld_rready;
    logic [3:0]  ld_rdst;
    logic [31:0] ld_rdata;
    logic        rf_wen0, rf_wbank0, rf_wen1, rf_wbank1;
    logic [3:0]  rf_wdst0, rf_wdst1;
    logic [31:0] rf_wdata0, rf_wdata1;
    logic [3:0]  chk_src0, chk_src1, chk_src2, chk_src3;
    logic        chk_bank0, chk_bank1, chk_bank2, chk_bank3;
    logic        chk_hit0, chk_hit1, chk_hit2, chk_hit3;
    logic [4:0]  ld_outstanding;

    int tests = 0;
    int fails = 0;
    int wen1_pulses;
    logic [31:0] rf [24];

    rf_wb_arb #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex0_wen(ex0_wen), .ex0_wdst(ex0_wdst), .ex0_wbank(ex0_wbank), .ex0_wdata(ex0_wdata),
        .ex1_wen(ex1_wen), .ex1_wdst(ex1_wdst), .ex1_wbank(ex1_wbank), .ex1_wdata(ex1_wdata),
        .ex1_stall(ex1_stall),
        .ld_issue(ld_issue), .ld_issue_dst(ld_issue_dst), .ld_issue_bank(ld_issue_bank),
        .ld_issue_ready(ld_issue_ready),
        .ld_rvalid(ld_rvalid), .ld_rdst(ld_rdst), .ld_rbank(ld_rbank), .ld_rdata(ld_rdata),
        .ld_rready(ld_rready),
        .rf_wen0(rf_wen0), .rf_wdst0(rf_wdst0), .rf_wbank0(rf_wbank0), .rf_wdata0(rf_wdata0),
        .rf_wen1(rf_wen1), .rf_wdst1(rf_wdst1), .rf_wbank1(rf_wbank1), .rf_wdata1(rf_wdata1),
        .chk_src0(chk_src0), .chk_src1(chk_src1), .chk_src2(chk_src2), .chk_src3(chk_src3),
        .chk_bank0(chk_bank0), .chk_bank1(chk_bank1), .chk_bank2(chk_bank2), .chk_bank3(chk_bank3),
        .chk_hit0(chk_hit0), .chk_hit1(chk_hit1), .chk_hit2(chk_hit2), .chk_hit3(chk_hit3),
        .ld_outstanding(ld_outstanding)
    );

    always #5 clk = ~clk;

    function automatic int pidx(input logic [3:0] dst, input logic bank);
        return (!dst[3] && bank) ? 16 + int'(dst[2:0]) : int'(dst);
    endfunction

    // Register file model written from the DUT write ports.
    always @(posedge clk) begin
        if (rf_wen0) rf[pidx(rf_wdst0, rf_wbank0)] <= rf_wdata0;
        if (rf_wen1) rf[pidx(rf_wdst1, rf_wbank1)] <= rf_wdata1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 24; i++) rf[i] = '0;
        rst_n = 1'b0;
        ex0_wen = 0; ex0_wdst = 0; ex0_wbank = 0; ex0_wdata = 0;
        ex1_wen = 0; ex1_wdst = 0; ex1_wbank = 0; ex1_wdata = 0;
        ld_issue = 0; ld_issue_dst = 0; ld_issue_bank = 0;
        ld_rvalid = 0; ld_rdst = 0; ld_rbank = 0; ld_rdata = 0;
        chk_src0 = 0; chk_src1 = 0; chk_src2 = 0; chk_src3 = 0;
        chk_bank0 = 0; chk_bank1 = 0; chk_bank2 = 0; chk_bank3 = 0;
        step(); step();
        #1;
        check("rst_ld_rready", 32'(ld_rready), 1);
        check("rst_issue_ready", 32'(ld_issue_ready), 1);
        check("rst_outstanding", 32'(ld_outstanding), 0);
        check("rst_stall", 32'(ex1_stall), 0);
        check("rst_wen1", 32'(rf_wen1), 0);
        check("rst_hit0", 32'(chk_hit0), 0);
        rst_n = 1'b1;
        step();

        // Same-cycle writes on both ports
        ex0_wen = 1; ex0_wdst = 4'd3; ex0_wdata = 32'h11;
        ex1_wen = 1; ex1_wdst = 4'd4; ex1_wdata = 32'h22;
        #1;
        check("p0_wen", 32'(rf_wen0), 1);
        check("p0_data", rf_wdata0, 32'h11);
        check("p1_wen", 32'(rf_wen1), 1);
        check("p1_dst", 32'(rf_wdst1), 4);
        check("p1_data", rf_wdata1, 32'h22);
        step();
        ex0_wen = 0; ex1_wen = 0;
        #1;
        check("rf_r3", rf[3], 32'h11);
        check("rf_r4", rf[4], 32'h22);

        // Load R5 bank1 -> index 21
        ld_issue = 1; ld_issue_dst = 4'd5; ld_issue_bank = 1;
        #1;
        check("r5_ready_before", 32'(ld_issue_ready), 1);
        step();
        ld_issue = 0;
        chk_src0 = 4'd5; chk_bank0 = 1; chk_src1 = 4'd5; chk_bank1 = 0;
        #1;
        check("r5b1_hit", 32'(chk_hit0), 1);
        check("r5b0_hit", 32'(chk_hit1), 0);
        check("r5_outstanding", 32'(ld_outstanding), 1);
        check("r5_ready_after", 32'(ld_issue_ready), 0);
        ld_rvalid = 1; ld_rdst = 4'd5; ld_rbank = 1; ld_rdata = 32'hDEAD;
        #1;
        check("r5_rready", 32'(ld_rready), 1);
        check("r5_no_bypass", 32'(rf_wen1), 0);
        step();
        ld_rvalid = 0;
        #1;
        check("r5_drain_wen", 32'(rf_wen1), 1);
        check("r5_drain_dst", 32'(rf_wdst1), 5);
        check("r5_drain_bank", 32'(rf_wbank1), 1);
        check("r5_drain_data", rf_wdata1, 32'hDEAD);
        step();
        check("r5_hit_clear", 32'(chk_hit0), 0);
        check("r5_out_zero", 32'(ld_outstanding), 0);
        check("rf_idx21", rf[21], 32'hDEAD);

        // Two loads fill the FIFO behind a busy ex1
        ld_issue = 1; ld_issue_dst = 4'd9; ld_issue_bank = 0;
        step();
        ld_issue_dst = 4'd1;
        step();
        ld_issue = 0;
        #1;
        check("two_outstanding", 32'(ld_outstanding), 2);
        ex1_wen = 1; ex1_wdst = 4'd2; ex1_wdata = 32'h33;
        ld_rvalid = 1; ld_rdst = 4'd1; ld_rbank = 0; ld_rdata = 32'h101;
        step();
        ld_rdst = 4'd9; ld_rdata = 32'h909;
        #1;
        check("fifo_half_rready", 32'(ld_rready), 1);
        step();
        ld_rvalid = 0;
        #1;
        check("fifo_full_rready", 32'(ld_rready), 0);
        check("ex1_priority", 32'(rf_wdst1), 2);
        ex1_wen = 0;
        #1;
        check("drain1_dst", 32'(rf_wdst1), 1);
        check("drain1_data", rf_wdata1, 32'h101);
        step();
        check("drain2_dst", 32'(rf_wdst1), 9);
        check("drain2_data", rf_wdata1, 32'h909);
        check("drain2_rready", 32'(ld_rready), 1);
        step();
        check("drained_wen1", 32'(rf_wen1), 0);
        check("drained_out", 32'(ld_outstanding), 0);
        check("rf_r9", rf[9], 32'h909);

        // Starvation of a buffered load
        ld_issue = 1; ld_issue_dst = 4'd6; ld_issue_bank = 0;
        step();
        ld_issue = 0;
        ex1_wen = 1; ex1_wdst = 4'd2; ex1_wdata = 32'h44;
        ld_rvalid = 1; ld_rdst = 4'd6; ld_rbank = 0; ld_rdata = 32'h606;
        step();
        ld_rvalid = 0;
        #1;
        check("starve_0", 32'(ex1_stall), 0);
        step(); step(); step();
        check("starve_3", 32'(ex1_stall), 0);
        step();
        check("starve_4", 32'(ex1_stall), 1);
        ex1_wen = 0;
        #1;
        check("starve_drain_dst", 32'(rf_wdst1), 6);
        check("starve_drain_wen", 32'(rf_wen1), 1);
        step();
        check("starve_fall", 32'(ex1_stall), 0);
        check("rf_r6", rf[6], 32'h606);

        // R8 is shared between banks
        ld_issue = 1; ld_issue_dst = 4'd8; ld_issue_bank = 1;
        step();
        ld_issue = 0; ld_issue_dst = 4'd8; ld_issue_bank = 0;
        chk_src2 = 4'd8; chk_bank2 = 1;
        #1;
        check("r8_shared_ready", 32'(ld_issue_ready), 0);
        check("r8_shared_hit", 32'(chk_hit2), 1);
        check("r8_outstanding", 32'(ld_outstanding), 1);

        // Asynchronous reset with buffered loads
        ld_issue = 1; ld_issue_dst = 4'd10; ld_issue_bank = 0;
        step();
        ld_issue_dst = 4'd11;
        step();
        ld_issue = 0;
        ex1_wen = 1; ex1_wdst = 4'd2; ex1_wdata = 32'h55;
        ld_rvalid = 1; ld_rdst = 4'd10; ld_rbank = 0; ld_rdata = 32'hA0;
        #1;
        check("pre_rst_out", 32'(ld_outstanding), 3);
        step();
        ld_rdst = 4'd11; ld_rdata = 32'hB0;
        step();
        ld_rvalid = 0;
        #1;
        check("pre_rst_full", 32'(ld_rready), 0);
        #1;
        rst_n = 1'b0;
        ex1_wen = 0;
        #1;
        check("arst_out", 32'(ld_outstanding), 0);
        check("arst_rready", 32'(ld_rready), 1);
        check("arst_hit2", 32'(chk_hit2), 0);
        check("arst_stall", 32'(ex1_stall), 0);
        check("arst_wen1", 32'(rf_wen1), 0);
        step();
        rst_n = 1'b1;
        wen1_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (rf_wen1) wen1_pulses++;
            step();
        end
        check("post_rst_pulses", 32'(wen1_pulses), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
